lcd_pixel_reader: RTL and testbench

Receive-side counterpart of the LCD panel writer. Samples the parallel RGB panel interface (hsync, vsync, den, 24-bit RGB) on cycles qualified by a pixel strobe, and recovers frame, line and pixel position. Emits a valid/ready pixel stream with x/y coordinates and checks frame geometry. Used for GPU output loopback capture, and as a video-input front end in the pipe_5 area.

---
 rtl/lcd_timing_pkg.sv | 38 +++
 rtl/lcd_pix_out_reg.sv | 82 ++++++++
 rtl/lcd_pixel_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_lcd_pixel_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing and encoding definitions for the LCD panel writer and reader.
// Holds the default panel geometry, porch widths, the reader FSM state
// encoding and the RGB field positions within the 24-bit pixel word.
package lcd_timing_pkg;

    // Default panel geometry (480x272).
    localparam int HOR_PIX = 480;
    localparam int VER_PIX = 272;

    // Porch widths used by the writer.
    localparam int THFP = 2;
    localparam int THBP = 43;
    localparam int TVFP = 1;
    localparam int TVBP = 12;

    // Pixel word layout: {R, G, B}.
    localparam int RGB_W = 24;
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC = 2'd0,
        ST_VBLANK     = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_HBLANK     = 2'd3
    } rd_state_e;

    function automatic logic [RGB_W-1:0] rgb_pack(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/lcd_pix_out_reg.sv
// Single-entry valid/ready holding register for the reader pixel stream.
// A held pixel stays put until out_ready_i; a new pixel arriving while the
// register is full and not being drained is dropped and flagged on drop_o.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i, in_*_i    new pixel from the decoder (single-cycle)
//   out_ready_i           downstream accept
//   out_valid_o, out_*_o  held pixel; sof/eol are gated by valid
//   drop_o                new pixel discarded this cycle
module lcd_pix_out_reg
    import lcd_timing_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [RGB_W-1:0] in_rgb_i,
    input  logic [XW-1:0]    in_x_i,
    input  logic [YW-1:0]    in_y_i,
    input  logic             in_sof_i,
    input  logic             in_eol_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [RGB_W-1:0] out_rgb_o,
    output logic [XW-1:0]    out_x_o,
    output logic [YW-1:0]    out_y_o,
    output logic             out_sof_o,
    output logic             out_eol_o,
    output logic             drop_o
);

    logic             valid_q, valid_d;
    logic             load;
    logic [RGB_W-1:0] rgb_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic             sof_q;
    logic             eol_q;

    // Loading while being drained keeps back-to-back throughput.
    assign load   = in_valid_i && (!valid_q || out_ready_i);
    assign drop_o = in_valid_i && valid_q && !out_ready_i;

    always_comb begin
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rgb_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                rgb_q <= in_rgb_i;
                x_q   <= in_x_i;
                y_q   <= in_y_i;
                sof_q <= in_sof_i;
                eol_q <= in_eol_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_rgb_o   = rgb_q;
    assign out_x_o     = x_q;
    assign out_y_o     = y_q;
    assign out_sof_o   = valid_q & sof_q;
    assign out_eol_o   = valid_q & eol_q;

endmodule

// File: rtl/lcd_pixel_reader.sv
// Receive side of the parallel RGB panel interface. Samples hsync/vsync/den/
// rgb on strobe-qualified cycles, recovers frame/line/pixel position and
// emits a valid/ready pixel stream with x/y coordinates and geometry checks.
// Ports:
//   clk_12mhz, reset            clock, synchronous active-high reset
//   pix_strobe                  cycle carries a panel dclk edge
//   hsync, vsync, den, rgb_in   panel interface (syncs active-low)
//   pix_ready                   downstream accept
//   err_clear                   clears the sticky error flags
//   pix_valid/rgb/x/y/sof/eol   pixel stream
//   frame_done                  pulse after the last line of a good frame
//   line_err, frame_err, ovf_err  sticky error flags
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_WAIT_VSYNC  | idle, den ignored until a vsync falling edge
// ST_VBLANK      | frame started, waiting for the first den sample (0,0)
// ST_ACTIVE      | inside a line, each den sample is a pixel
// ST_HBLANK      | between lines, next den sample starts line y+1
module lcd_pixel_reader #(
    parameter int HOR_PIX = lcd_timing_pkg::HOR_PIX,
    parameter int VER_PIX = lcd_timing_pkg::VER_PIX,
    parameter int XW      = 9,
    parameter int YW      = 9
) (
    input  logic          clk_12mhz,
    input  logic          reset,
    input  logic          pix_strobe,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          den,
    input  logic [23:0]   rgb_in,
    input  logic          pix_ready,
    input  logic          err_clear,
    output logic          pix_valid,
    output logic [23:0]   pix_rgb,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          frame_done,
    output logic          line_err,
    output logic          frame_err,
    output logic          ovf_err
);
    import lcd_timing_pkg::*;

    localparam logic [XW-1:0] X_FULL = XW'(HOR_PIX);
    localparam logic [XW-1:0] X_LAST = XW'(HOR_PIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VER_PIX - 1);

    rd_state_e     state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          long_q, long_d;
    logic          hs_q, vs_q, den_q;
    logic          done_q, done_d;
    logic          line_err_q, line_err_d;
    logic          frame_err_q, frame_err_d;
    logic          ovf_err_q, ovf_err_d;

    logic          vs_fall, hs_fall, den_fall, den_s;
    logic          x_full;
    logic [YW-1:0] y_inc;
    logic          emit;
    logic [XW-1:0] emit_x;
    logic [YW-1:0] emit_y;
    logic          set_line, set_frame;
    logic          drop;

    // Edges are taken against the previous strobed sample only.
    assign vs_fall  = pix_strobe & vs_q & ~vsync;
    assign hs_fall  = pix_strobe & hs_q & ~hsync;
    assign den_fall = pix_strobe & den_q & ~den;
    assign den_s    = pix_strobe & den;
    assign x_full   = (x_q == X_FULL);
    // Saturate so a runaway frame cannot wrap back to row 0.
    assign y_inc    = (y_q == '1) ? y_q : y_q + YW'(1);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        long_d    = long_q;
        done_d    = 1'b0;
        emit      = 1'b0;
        emit_x    = x_q;
        emit_y    = y_q;
        set_line  = 1'b0;
        set_frame = 1'b0;

        if (vs_fall) begin
            // vsync wins over a coincident den sample.
            if (state_q == ST_ACTIVE || state_q == ST_HBLANK) begin
                set_frame = 1'b1;
            end
            state_d = ST_VBLANK;
            x_d     = '0;
            y_d     = '0;
            long_d  = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_VSYNC: begin
                end
                ST_VBLANK: begin
                    if (den_s) begin
                        emit    = 1'b1;
                        emit_x  = '0;
                        emit_y  = '0;
                        x_d     = XW'(1);
                        y_d     = '0;
                        long_d  = 1'b0;
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (hs_fall) begin
                        set_line = 1'b1;
                    end
                    if (den_s) begin
                        if (x_full) begin
                            // Excess pixel: dropped, x stays saturated.
                            set_line = 1'b1;
                            long_d   = 1'b1;
                        end else begin
                            emit = 1'b1;
                            x_d  = x_q + XW'(1);
                        end
                    end else if (den_fall) begin
                        if (!x_full) begin
                            set_line = 1'b1;
                        end
                        if (x_full && !long_q && y_q == Y_LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_WAIT_VSYNC;
                        end else begin
                            state_d = ST_HBLANK;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (den_s) begin
                        emit    = 1'b1;
                        emit_x  = '0;
                        emit_y  = y_inc;
                        x_d     = XW'(1);
                        y_d     = y_inc;
                        long_d  = 1'b0;
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    state_d = ST_WAIT_VSYNC;
                end
            endcase
        end
    end

    // A new error in the same cycle as err_clear keeps the flag set.
    always_comb begin
        line_err_d  = (line_err_q  & ~err_clear) | set_line;
        frame_err_d = (frame_err_q & ~err_clear) | set_frame;
        ovf_err_d   = (ovf_err_q   & ~err_clear) | drop;
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state_q     <= ST_WAIT_VSYNC;
            x_q         <= '0;
            y_q         <= '0;
            long_q      <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            den_q       <= 1'b0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            long_q      <= long_d;
            done_q      <= done_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
            if (pix_strobe) begin
                hs_q  <= hsync;
                vs_q  <= vsync;
                den_q <= den;
            end
        end
    end

    lcd_pix_out_reg #(
        .XW (XW),
        .YW (YW)
    ) u_out_reg (
        .clk_i       (clk_12mhz),
        .rst_i       (reset),
        .in_valid_i  (emit),
        .in_rgb_i    (rgb_in),
        .in_x_i      (emit_x),
        .in_y_i      (emit_y),
        .in_sof_i    ((emit_x == '0) && (emit_y == '0)),
        .in_eol_i    (emit_x == X_LAST),
        .out_ready_i (pix_ready),
        .out_valid_o (pix_valid),
        .out_rgb_o   (pix_rgb),
        .out_x_o     (pix_x),
        .out_y_o     (pix_y),
        .out_sof_o   (pix_sof),
        .out_eol_o   (pix_eol),
        .drop_o      (drop)
    );

    assign frame_done = done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_lcd_pixel_reader.sv
// Directed bench for lcd_pixel_reader on a reduced 8x4 geometry.
module tb_lcd_pixel_reader;
    import lcd_timing_pkg::*;

    localparam int HP = 8;
    localparam int VP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_strobe, hsync, vsync, den, pix_ready, err_clear;
    logic [23:0] rgb_in;
    logic        pix_valid, pix_sof, pix_eol, frame_done;
    logic        line_err, frame_err, ovf_err;
    logic [23:0] pix_rgb;
    logic [8:0]  pix_x, pix_y;

    int n_assert = 0;
    int n_fail   = 0;
    bit half     = 1'b0;

    lcd_pixel_reader #(.HOR_PIX(HP), .VER_PIX(VP), .XW(9), .YW(9)) dut (
        .clk_12mhz (clk),
        .reset     (reset),
        .pix_strobe(pix_strobe),
        .hsync     (hsync),
        .vsync     (vsync),
        .den       (den),
        .rgb_in    (rgb_in),
        .pix_ready (pix_ready),
        .err_clear (err_clear),
        .pix_valid (pix_valid),
        .pix_rgb   (pix_rgb),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .frame_done(frame_done),
        .line_err  (line_err),
        .frame_err (frame_err),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] px(input int y, input int x);
        return rgb_pack(8'(y), 8'(x), 8'h5A);
    endfunction

    // One panel sample; in half mode a non-strobed cycle carrying junk
    // (vsync low, den high) precedes it and must be ignored.
    task automatic cyc(input logic stb, input logic vs, input logic hs,
                       input logic de, input logic [23:0] rgb);
        if (half && stb) begin
            pix_strobe = 1'b0; vsync = 1'b0; hsync = 1'b0; den = 1'b1;
            rgb_in = 24'hDEAD00;
            @(posedge clk); #1;
        end
        pix_strobe = stb; vsync = vs; hsync = hs; den = de; rgb_in = rgb;
        @(posedge clk); #1;
    endtask

    task automatic frame_start();
        cyc(1, 0, 1, 0, 24'h0);
        cyc(1, 1, 1, 0, 24'h0);
        cyc(1, 1, 1, 0, 24'h0);
    endtask

    task automatic send_line(input int y, input int npix);
        logic exp_done;
        exp_done = (npix == HP) && (y == VP - 1);
        cyc(1, 1, 0, 0, 24'h0);
        cyc(1, 1, 1, 0, 24'h0);
        for (int x = 0; x < npix; x++) begin
            cyc(1, 1, 1, 1, px(y, x));
            if (x < HP) begin
                chk("valid", 64'(pix_valid), 64'd1);
                chk("x", 64'(pix_x), 64'(x));
                chk("y", 64'(pix_y), 64'(y));
                chk("rgb", 64'(pix_rgb), 64'(px(y, x)));
                chk("sof", 64'(pix_sof), 64'((x == 0) && (y == 0)));
                chk("eol", 64'(pix_eol), 64'(x == HP - 1));
            end else begin
                chk("excess_drop", 64'(pix_valid), 64'd0);
            end
        end
        cyc(1, 1, 1, 0, 24'h0);
        chk("frame_done", 64'(frame_done), 64'(exp_done));
        cyc(1, 1, 1, 0, 24'h0);
        chk("frame_done_pulse", 64'(frame_done), 64'd0);
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        cyc(1, 1, 1, 0, 24'h0);
        err_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pix_strobe = 1'b0; hsync = 1'b1; vsync = 1'b1;
        den = 1'b0; rgb_in = '0; pix_ready = 1'b1; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_valid", 64'(pix_valid), 64'd0);
        chk("rst_rgb", 64'(pix_rgb), 64'd0);
        chk("rst_xy", 64'({pix_x, pix_y}), 64'd0);
        chk("rst_flags", 64'({pix_sof, pix_eol, frame_done, line_err, frame_err, ovf_err}), 64'd0);

        // den before any vsync edge is ignored
        cyc(1, 1, 1, 1, 24'h123456);
        chk("pre_vsync_den", 64'(pix_valid), 64'd0);

        // full frame, continuous strobe
        frame_start();
        for (int y = 0; y < VP; y++) send_line(y, HP);
        chk("f1_errs", 64'({line_err, frame_err, ovf_err}), 64'd0);
        cyc(1, 1, 1, 1, 24'h0);
        chk("post_frame_den", 64'(pix_valid), 64'd0);
        cyc(1, 1, 1, 0, 24'h0);

        // full frame, 50% strobe with junk on idle cycles
        half = 1'b1;
        frame_start();
        for (int y = 0; y < VP; y++) send_line(y, HP);
        chk("f2_errs", 64'({line_err, frame_err, ovf_err}), 64'd0);
        half = 1'b0;

        // short line, over-long line, then vsync mid-frame
        frame_start();
        send_line(0, HP);
        chk("no_line_err", 64'(line_err), 64'd0);
        send_line(1, HP - 1);
        chk("short_line_err", 64'(line_err), 64'd1);
        clear_errs();
        chk("line_err_clr", 64'(line_err), 64'd0);
        send_line(2, HP + 1);
        chk("long_line_err", 64'(line_err), 64'd1);
        clear_errs();
        chk("frame_err_pre", 64'({line_err, frame_err}), 64'd0);
        frame_start();
        chk("frame_err", 64'(frame_err), 64'd1);
        for (int y = 0; y < VP; y++) send_line(y, HP);
        chk("frame_err_sticky", 64'({line_err, frame_err}), 64'b01);
        clear_errs();
        chk("frame_err_clr", 64'(frame_err), 64'd0);

        // overflow: ready low over three pixels
        frame_start();
        cyc(1, 1, 0, 0, 24'h0);
        cyc(1, 1, 1, 0, 24'h0);
        pix_ready = 1'b0;
        cyc(1, 1, 1, 1, px(0, 0));
        chk("ovf_p0_valid", 64'({pix_valid, pix_sof}), 64'b11);
        chk("ovf_p0_x", 64'(pix_x), 64'd0);
        cyc(1, 1, 1, 1, px(0, 1));
        chk("ovf_set", 64'(ovf_err), 64'd1);
        chk("ovf_hold_rgb", 64'(pix_rgb), 64'(px(0, 0)));
        err_clear = 1'b1;
        cyc(1, 1, 1, 1, px(0, 2));
        err_clear = 1'b0;
        chk("ovf_err_wins", 64'(ovf_err), 64'd1);
        chk("ovf_hold_x", 64'({pix_valid, pix_x}), 64'({1'b1, 9'd0}));
        pix_ready = 1'b1;
        cyc(1, 1, 1, 1, px(0, 3));
        chk("b2b_load_x", 64'(pix_x), 64'd3);
        chk("b2b_load_rgb", 64'(pix_rgb), 64'(px(0, 3)));
        err_clear = 1'b1;
        cyc(1, 1, 1, 1, px(0, 4));
        err_clear = 1'b0;
        chk("ovf_clr", 64'(ovf_err), 64'd0);
        chk("ovf_x4", 64'(pix_x), 64'd4);
        for (int x = 5; x < HP; x++) cyc(1, 1, 1, 1, px(0, x));
        chk("ovf_last_eol", 64'({pix_valid, pix_eol, pix_x}), 64'({2'b11, 9'd7}));
        cyc(1, 1, 1, 0, 24'h0);
        chk("ovf_line_ok", 64'(line_err), 64'd0);
        send_line(1, HP);

        // hsync edge inside a line, then reset mid-line
        cyc(1, 1, 0, 0, 24'h0);
        cyc(1, 1, 1, 0, 24'h0);
        cyc(1, 1, 1, 1, px(2, 0));
        chk("l2_y", 64'(pix_y), 64'd2);
        cyc(1, 1, 0, 1, px(2, 1));
        chk("hsync_line_err", 64'(line_err), 64'd1);
        chk("hsync_pix_x", 64'(pix_x), 64'd1);
        cyc(1, 1, 1, 1, px(2, 2));
        reset = 1'b1;
        cyc(1, 1, 1, 1, px(2, 3));
        reset = 1'b0;
        chk("mid_rst_valid", 64'(pix_valid), 64'd0);
        chk("mid_rst_rgb", 64'(pix_rgb), 64'd0);
        chk("mid_rst_xy", 64'({pix_x, pix_y}), 64'd0);
        chk("mid_rst_flags", 64'({pix_sof, pix_eol, frame_done, line_err, frame_err, ovf_err}), 64'd0);
        cyc(1, 1, 1, 1, px(2, 4));
        cyc(1, 1, 1, 1, px(2, 5));
        chk("post_rst_den", 64'(pix_valid), 64'd0);
        cyc(1, 0, 1, 1, px(9, 9));
        chk("vsync_beats_den", 64'(pix_valid), 64'd0);
        cyc(1, 1, 1, 1, px(0, 0));
        chk("restart_valid", 64'({pix_valid, pix_sof}), 64'b11);
        chk("restart_xy", 64'({pix_x, pix_y}), 64'd0);
        chk("restart_rgb", 64'(pix_rgb), 64'(px(0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
